// File: rtl/mesh_term_tx_if.sv
// mesh_term_tx_if -- host/router bundle for the mesh terminal transmit buffer.
//
// Host side : push_i, row_i, col_i, mode_i, bcast_i, payload_i in; full_o out.
// Router side: pndng_o, data_out_o out; popin_i in.
// Status    : count_o (occupancy), ovf_o (sticky overflow), drop_cnt_o.
//
// The slave modport is the buffer itself; the master modport is whatever
// drives pushes and pops (host plus router terminal, or a testbench).
interface mesh_term_tx_if #(
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                   push_i;
    logic [3:0]             row_i;
    logic [3:0]             col_i;
    logic                   mode_i;
    logic                   bcast_i;
    logic [PAKG_SIZE-18:0]  payload_i;
    logic                   full_o;
    logic                   pndng_o;
    logic [PAKG_SIZE-1:0]   data_out_o;
    logic                   popin_i;
    logic [CNT_W-1:0]       count_o;
    logic                   ovf_o;
    logic [7:0]             drop_cnt_o;

    modport slave (
        input  push_i, row_i, col_i, mode_i, bcast_i, payload_i, popin_i,
        output full_o, pndng_o, data_out_o, count_o, ovf_o, drop_cnt_o
    );

    modport master (
        output push_i, row_i, col_i, mode_i, bcast_i, payload_i, popin_i,
        input  full_o, pndng_o, data_out_o, count_o, ovf_o, drop_cnt_o
    );
endinterface

// File: rtl/mesh_term_tx.sv
// mesh_term_tx -- transmit buffer between a host and a mesh router terminal.
//
// Formats host requests into packets and queues them in a first-word-fall-
// through buffer feeding the router's terminal input.
//
// Packet layout (MSB first):
//   next-jump [P-1:P-8]  (BDCST on broadcast, else 0)
//   row       [P-9:P-12]
//   column    [P-13:P-16]
//   mode      [P-17]
//   payload   [P-18:0]
//
// Ports:
//   clk_i  : single clock, rising edge.
//   rst_i  : asynchronous, active-low reset.
//   bus    : mesh_term_tx_if.slave -- host push side, router pop side, status.
//
// Pushes addressed outside the mesh, or arriving while full with no pop in
// the same cycle, are dropped and counted (saturating at 255). Only a full-
// buffer drop sets the sticky overflow flag.
module mesh_term_tx #(
    parameter int         PAKG_SIZE  = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter int         ROWS       = 4,
    parameter int         COLUMNS    = 4,
    parameter logic [7:0] BDCST      = 8'hFF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mesh_term_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Highest legal row/column index; kept 5 bits wide so ROWS+1 up to 31 fits.
    localparam logic [4:0] ROW_LIM = 5'(ROWS + 1);
    localparam logic [4:0] COL_LIM = 5'(COLUMNS + 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PAKG_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 ovf_q,    ovf_d;
    logic [7:0]           drop_q,   drop_d;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic                 addr_ok;
    logic                 full;
    logic                 pending;
    logic                 pop_fire;
    logic                 push_acc;
    logic                 push_drop;
    logic [PAKG_SIZE-1:0] pkt;

    assign addr_ok  = ({1'b0, bus.row_i} <= ROW_LIM) && ({1'b0, bus.col_i} <= COL_LIM);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pending  = (count_q != '0);

    // A pop with nothing pending is ignored outright.
    assign pop_fire = bus.popin_i && pending;

    // A same-cycle pop frees the slot, so a full buffer can still accept.
    assign push_acc  = bus.push_i && addr_ok && (!full || pop_fire);
    assign push_drop = bus.push_i && !push_acc;

    assign pkt = {(bus.bcast_i ? BDCST : 8'h00),
                  bus.row_i, bus.col_i, bus.mode_i, bus.payload_i};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned -- that is what keeps a combinational block latch-free.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        // Pointers wrap naturally since FIFO_DEPTH is a power of two.
        if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push_acc, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        // Out-of-mesh drops are bad addressing, not congestion: no overflow.
        if (push_drop && addr_ok) ovf_d = 1'b1;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value regardless of statement order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the count
    // gates every read, so stale contents are never visible and the array
    // can map onto plain RAM/flops without a reset network.
    always_ff @(posedge clk_i) begin
        if (push_acc) mem_q[wr_ptr_q] <= pkt;
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // Head entry falls through from registered storage; forced to zero when
    // empty so the router never sees stale data (and reset clears it at once).
    assign bus.data_out_o = pending ? mem_q[rd_ptr_q] : '0;
    assign bus.pndng_o    = pending;
    assign bus.full_o     = full;
    assign bus.count_o    = count_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.drop_cnt_o = drop_q;

endmodule

// File: tb/tb_mesh_term_tx.sv
// tb_mesh_term_tx -- directed self-checking bench for mesh_term_tx
// (PAKG_SIZE=32, FIFO_DEPTH=16, ROWS=4, COLUMNS=4, BDCST=8'hFF).
module tb_mesh_term_tx;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    mesh_term_tx_if #(.PAKG_SIZE(32), .FIFO_DEPTH(16)) bus ();

    mesh_term_tx #(
        .PAKG_SIZE (32),
        .FIFO_DEPTH(16),
        .ROWS      (4),
        .COLUMNS   (4),
        .BDCST     (8'hFF)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Expected packet built from the field layout: jump|row|col|mode|payload[14:0].
    function automatic logic [31:0] mk(input logic bc, input logic [3:0] r,
                                       input logic [3:0] c, input logic m,
                                       input logic [14:0] p);
        return {(bc ? 8'hFF : 8'h00), r, c, m, p};
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic bc, input logic [3:0] r, input logic [3:0] c,
                        input logic m, input logic [14:0] p, input logic pop);
        bus.push_i    = 1'b1;
        bus.bcast_i   = bc;
        bus.row_i     = r;
        bus.col_i     = c;
        bus.mode_i    = m;
        bus.payload_i = p;
        bus.popin_i   = pop;
        step();
        bus.push_i  = 1'b0;
        bus.popin_i = 1'b0;
    endtask

    task automatic pop();
        bus.popin_i = 1'b1;
        step();
        bus.popin_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".count"}, 32'(bus.count_o),    32'd0);
        check({tag, ".pndng"}, 32'(bus.pndng_o),    32'd0);
        check({tag, ".full"},  32'(bus.full_o),     32'd0);
        check({tag, ".ovf"},   32'(bus.ovf_o),      32'd0);
        check({tag, ".drop"},  32'(bus.drop_cnt_o), 32'd0);
        check({tag, ".data"},  bus.data_out_o,      32'd0);
    endtask

    initial begin
        bus.push_i    = 1'b0;
        bus.popin_i   = 1'b0;
        bus.bcast_i   = 1'b0;
        bus.row_i     = 4'd0;
        bus.col_i     = 4'd0;
        bus.mode_i    = 1'b0;
        bus.payload_i = 15'd0;

        // Reset state
        #1;
        check_zero("reset");
        #20;
        rst_i = 1'b1;
        step();

        // Single packet: mode sits at bit 15, so 0x1234 with mode=1 reads 0x9234.
        push(1'b0, 4'd0, 4'd2, 1'b1, 15'h1234, 1'b0);
        check("basic.pndng", 32'(bus.pndng_o), 32'd1);
        check("basic.data",  bus.data_out_o,   32'h0002_9234);
        check("basic.count", 32'(bus.count_o), 32'd1);
        pop();
        check("basic.pop_pndng", 32'(bus.pndng_o), 32'd0);
        check("basic.pop_data",  bus.data_out_o,   32'd0);

        // Pop while empty is ignored
        pop();
        check("empty_pop.count", 32'(bus.count_o), 32'd0);

        // Out-of-mesh addresses: row 7, then column 6; ovf must stay clear
        push(1'b0, 4'd7, 4'd1, 1'b0, 15'h0001, 1'b0);
        exp_drop++;
        check("bad_row.count", 32'(bus.count_o),    32'd0);
        check("bad_row.drop",  32'(bus.drop_cnt_o), 32'(exp_drop));
        check("bad_row.ovf",   32'(bus.ovf_o),      32'd0);
        push(1'b0, 4'd1, 4'd6, 1'b0, 15'h0002, 1'b0);
        exp_drop++;
        check("bad_col.drop",  32'(bus.drop_cnt_o), 32'(exp_drop));
        check("bad_col.pndng", 32'(bus.pndng_o),    32'd0);

        // Edge of the legal range (ROWS+1, COLUMNS+1) is accepted
        push(1'b0, 4'd5, 4'd5, 1'b0, 15'h7FFF, 1'b0);
        check("edge.data", bus.data_out_o, mk(1'b0, 4'd5, 4'd5, 1'b0, 15'h7FFF));
        check("edge.drop", 32'(bus.drop_cnt_o), 32'(exp_drop));
        pop();

        // Broadcast marker in the next-jump field
        push(1'b1, 4'd3, 4'd1, 1'b0, 15'h0055, 1'b0);
        check("bcast.jump", 32'(bus.data_out_o[31:24]), 32'hFF);
        check("bcast.data", bus.data_out_o, 32'hFF31_0055);
        pop();

        // Fill to capacity with distinct packets
        for (int i = 0; i < 16; i++) begin
            logic [3:0] r, c;
            r = 4'(i % 6);
            c = 4'((i * 3) % 6);
            push(1'b0, r, c, i[0], 15'(i + 1), 1'b0);
            exp_q.push_back(mk(1'b0, r, c, i[0], 15'(i + 1)));
        end
        check("fill.full",  32'(bus.full_o),  32'd1);
        check("fill.count", 32'(bus.count_o), 32'd16);
        check("fill.ovf",   32'(bus.ovf_o),   32'd0);

        // 17th push is dropped and sets overflow
        push(1'b0, 4'd1, 4'd1, 1'b1, 15'h0ABC, 1'b0);
        exp_drop++;
        check("ovf17.count", 32'(bus.count_o),    32'd16);
        check("ovf17.ovf",   32'(bus.ovf_o),      32'd1);
        check("ovf17.drop",  32'(bus.drop_cnt_o), 32'(exp_drop));
        check("ovf17.head",  bus.data_out_o,      exp_q[0]);

        // Full buffer, push and pop together: accepted, no drop
        push(1'b0, 4'd2, 4'd4, 1'b1, 15'h0777, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(mk(1'b0, 4'd2, 4'd4, 1'b1, 15'h0777));
        check("pushpop.count", 32'(bus.count_o),    32'd16);
        check("pushpop.drop",  32'(bus.drop_cnt_o), 32'(exp_drop));
        check("pushpop.full",  32'(bus.full_o),     32'd1);

        // Drain in order (also exercises pointer wrap)
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), bus.data_out_o, exp_q.pop_front());
            pop();
        end
        check("drain.count", 32'(bus.count_o), 32'd0);
        check("drain.data",  bus.data_out_o,   32'd0);
        check("drain.ovf",   32'(bus.ovf_o),   32'd1);

        // Saturation: refill, then 300 overflow drops
        for (int i = 0; i < 16; i++) push(1'b0, 4'd0, 4'd0, 1'b0, 15'(i), 1'b0);
        for (int i = 0; i < 300; i++) push(1'b0, 4'd1, 4'd1, 1'b0, 15'd9, 1'b0);
        check("sat.drop",  32'(bus.drop_cnt_o), 32'd255);
        check("sat.count", 32'(bus.count_o),    32'd16);
        check("sat.head",  bus.data_out_o,      mk(1'b0, 4'd0, 4'd0, 1'b0, 15'd0));

        // Reset mid-burst: clean restart, five entries, then async reset
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        step();
        for (int i = 0; i < 5; i++) push(1'b0, 4'd1, 4'd2, 1'b0, 15'(100 + i), 1'b0);
        check("burst.count", 32'(bus.count_o), 32'd5);
        #2;
        rst_i = 1'b0;
        #1;
        check_zero("async_rst");
        #10;
        rst_i = 1'b1;
        step();
        push(1'b1, 4'd4, 4'd3, 1'b1, 15'h2468, 1'b0);
        check("post_rst.count", 32'(bus.count_o), 32'd1);
        check("post_rst.head",  bus.data_out_o,   mk(1'b1, 4'd4, 4'd3, 1'b1, 15'h2468));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
